uart_rx_multi: RTL and testbench

//  Parametrised UART receiver: 2-FF input sync, oversampled start/data/stop sampling, optional parity check.

---
 rtl/uart_pkg.sv | 35 +++
 rtl/uart_rx_fifo.sv | 69 ++++++
 rtl/uart_rx_multi.sv | 222 ++++++++++++++++++++++
 tb/tb_uart_rx_multi.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module : uart_pkg
// Brief  : Shared UART types and elaboration helpers (receiver and future tx).
// Rev    : 1.0  initial release
// ============================================================================
package uart_pkg;

   typedef enum logic [2:0] {
      S_INIT   = 3'd0,
      S_IDLE   = 3'd1,
      S_START  = 3'd2,
      S_DATA   = 3'd3,
      S_PARITY = 3'd4,
      S_STOP   = 3'd5
   } rx_state_t;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         r++;
      end
      return r;
   endfunction

   // Clocks per oversample tick, never below one.
   function automatic int calc_div(input int clk_hz, input int baud, input int oversample);
      int d;
      d = clk_hz / (baud * oversample);
      return (d < 1) ? 1 : d;
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module : uart_rx_fifo
// Brief  : Synchronous first-word-fall-through FIFO for received UART words.
// Rev    : 1.0  initial release
// ============================================================================
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int P_WIDTH = 8,
   parameter int P_DEPTH = 16
) (
   input  logic               CLK,
   input  logic               reset,
   input  logic [P_WIDTH-1:0] din,
   input  logic               wr_en,
   input  logic               rd_en,
   output logic [P_WIDTH-1:0] dout,
   output logic               full,
   output logic               empty
);

   localparam int             c_AW       = clog2(P_DEPTH);
   localparam logic [c_AW-1:0] c_PTR_ONE = c_AW'(1);
   localparam logic [c_AW:0]   c_CNT_ONE = (c_AW + 1)'(1);
   localparam logic [c_AW:0]   c_CNT_MAX = (c_AW + 1)'(P_DEPTH);

   logic [P_WIDTH-1:0] r_mem [P_DEPTH];
   logic [c_AW-1:0]    r_wptr;
   logic [c_AW-1:0]    r_rptr;
   logic [c_AW:0]      r_count;
   logic               w_do_wr;
   logic               w_do_rd;

   assign empty   = (r_count == '0);
   assign full    = (r_count == c_CNT_MAX);
   assign w_do_rd = rd_en & ~empty;
   // A write into a full FIFO is only legal when the head leaves in the same cycle.
   assign w_do_wr = wr_en & (~full | rd_en);
   assign dout    = empty ? '0 : r_mem[r_rptr];

   always_ff @(posedge CLK) begin
      if (w_do_wr) begin
         r_mem[r_wptr] <= din;
      end
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_do_wr) begin
            r_wptr <= r_wptr + c_PTR_ONE;
         end
         if (w_do_rd) begin
            r_rptr <= r_rptr + c_PTR_ONE;
         end
         case ({w_do_wr, w_do_rd})
            2'b10:   r_count <= r_count + c_CNT_ONE;
            2'b01:   r_count <= r_count - c_CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/uart_rx_multi.sv
`default_nettype none
// ============================================================================
// Module : uart_rx_multi
// Brief  : Oversampling UART receiver with word FIFO and sticky error flags.
//          Define UART_RX_PARITY_EN to insert the parity bit and parity_error.
// Rev    : 1.0  initial release
// ============================================================================
module uart_rx_multi
   import uart_pkg::*;
#(
   parameter int P_DATA_BITS  = 8,
   parameter int P_CLK_HZ     = 500000000,
   parameter int P_BAUD       = 9600,
   parameter int P_OVERSAMPLE = 16,
   parameter int P_FIFO_DEPTH = 16,
   parameter int P_IDLE_BITS  = 10,
   parameter int P_PARITY_ODD = 0
) (
   input  logic                   CLK,
   input  logic                   reset,
   input  logic                   serial_in,
   input  logic                   rd_en,
   input  logic                   clear_errors,
   output logic [P_DATA_BITS-1:0] data_out,
   output logic                   fifo_full,
   output logic                   fifo_empty,
   output logic                   frame_error,
   output logic                   overrun_error,
   output logic                   parity_error
);

   localparam int c_DIV        = calc_div(P_CLK_HZ, P_BAUD, P_OVERSAMPLE);
   localparam int c_DIV_W      = (clog2(c_DIV) < 1) ? 1 : clog2(c_DIV);
   localparam int c_IDLE_TICKS = P_IDLE_BITS * P_OVERSAMPLE;
   localparam int c_SC_W       = clog2(c_IDLE_TICKS + 1);
   localparam int c_BC_W       = (clog2(P_DATA_BITS) < 1) ? 1 : clog2(P_DATA_BITS);

   localparam logic [c_DIV_W-1:0] c_DIV_LAST  = c_DIV_W'(c_DIV - 1);
   localparam logic [c_DIV_W-1:0] c_DIV_ONE   = c_DIV_W'(1);
   localparam logic [c_SC_W-1:0]  c_IDLE_LAST = c_SC_W'(c_IDLE_TICKS - 1);
   localparam logic [c_SC_W-1:0]  c_HALF_LAST = c_SC_W'(P_OVERSAMPLE / 2 - 1);
   localparam logic [c_SC_W-1:0]  c_BIT_LAST  = c_SC_W'(P_OVERSAMPLE - 1);
   localparam logic [c_SC_W-1:0]  c_SC_ONE    = c_SC_W'(1);
   localparam logic [c_BC_W-1:0]  c_BC_LAST   = c_BC_W'(P_DATA_BITS - 1);
   localparam logic [c_BC_W-1:0]  c_BC_ONE    = c_BC_W'(1);
   localparam logic               c_PAR_ODD   = 1'(P_PARITY_ODD);

   logic [c_DIV_W-1:0]     r_div;
   logic                   w_tick;
   logic                   r_sync_meta;
   logic                   r_rx_s;
   rx_state_t              r_state;
   logic [c_SC_W-1:0]      r_sc;
   logic [c_BC_W-1:0]      r_bc;
   logic [P_DATA_BITS-1:0] r_shreg;
   logic                   r_par_bad;
   logic                   r_wr_en;
   logic                   r_frame_error;
   logic                   r_overrun_error;
`ifdef UART_RX_PARITY_EN
   logic                   r_parity_error;
`endif

   assign w_tick = (r_div == c_DIV_LAST);

   always_ff @(posedge CLK) begin
      if (reset) begin
         r_div <= '0;
      end else if (w_tick) begin
         r_div <= '0;
      end else begin
         r_div <= r_div + c_DIV_ONE;
      end
   end

   // Sync flops reset to the idle level so reset never looks like a start bit.
   always_ff @(posedge CLK) begin
      if (reset) begin
         r_sync_meta <= 1'b1;
         r_rx_s      <= 1'b1;
      end else begin
         r_sync_meta <= serial_in;
         r_rx_s      <= r_sync_meta;
      end
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         r_state         <= S_INIT;
         r_sc            <= '0;
         r_bc            <= '0;
         r_shreg         <= '0;
         r_par_bad       <= 1'b0;
         r_wr_en         <= 1'b0;
         r_frame_error   <= 1'b0;
         r_overrun_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_parity_error  <= 1'b0;
`endif
      end else begin
         r_wr_en <= 1'b0;
         // Clears come first so that a same-cycle set below takes priority.
         if (clear_errors) begin
            r_frame_error   <= 1'b0;
            r_overrun_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_error  <= 1'b0;
`endif
         end
         if (r_wr_en && fifo_full && !rd_en) begin
            r_overrun_error <= 1'b1;
         end
         if (w_tick) begin
            case (r_state)
               S_INIT: begin
                  if (!r_rx_s) begin
                     r_sc <= '0;
                  end else if (r_sc == c_IDLE_LAST) begin
                     r_sc    <= '0;
                     r_state <= S_IDLE;
                  end else begin
                     r_sc <= r_sc + c_SC_ONE;
                  end
               end
               S_IDLE: begin
                  if (!r_rx_s) begin
                     r_sc    <= '0;
                     r_state <= S_START;
                  end
               end
               S_START: begin
                  if (r_sc == c_HALF_LAST) begin
                     r_sc <= '0;
                     if (r_rx_s) begin
                        r_state <= S_IDLE;
                     end else begin
                        r_bc      <= '0;
                        r_par_bad <= 1'b0;
                        r_state   <= S_DATA;
                     end
                  end else begin
                     r_sc <= r_sc + c_SC_ONE;
                  end
               end
               S_DATA: begin
                  if (r_sc == c_BIT_LAST) begin
                     r_sc    <= '0;
                     r_shreg <= {r_rx_s, r_shreg[P_DATA_BITS-1:1]};
                     if (r_bc == c_BC_LAST) begin
`ifdef UART_RX_PARITY_EN
                        r_state <= S_PARITY;
`else
                        r_state <= S_STOP;
`endif
                     end else begin
                        r_bc <= r_bc + c_BC_ONE;
                     end
                  end else begin
                     r_sc <= r_sc + c_SC_ONE;
                  end
               end
               S_PARITY: begin
                  if (r_sc == c_BIT_LAST) begin
                     r_sc      <= '0;
                     r_par_bad <= r_rx_s ^ (^r_shreg) ^ c_PAR_ODD;
                     r_state   <= S_STOP;
                  end else begin
                     r_sc <= r_sc + c_SC_ONE;
                  end
               end
               S_STOP: begin
                  if (r_sc == c_BIT_LAST) begin
                     r_sc <= '0;
`ifdef UART_RX_PARITY_EN
                     if (r_par_bad) begin
                        r_parity_error <= 1'b1;
                     end
`endif
                     if (r_rx_s) begin
                        r_wr_en <= ~r_par_bad;
                        r_state <= S_IDLE;
                     end else begin
                        r_frame_error <= 1'b1;
                        r_state       <= S_INIT;
                     end
                  end else begin
                     r_sc <= r_sc + c_SC_ONE;
                  end
               end
               default: begin
                  r_sc    <= '0;
                  r_state <= S_INIT;
               end
            endcase
         end
      end
   end

   assign frame_error   = r_frame_error;
   assign overrun_error = r_overrun_error;
`ifdef UART_RX_PARITY_EN
   assign parity_error  = r_parity_error;
`else
   assign parity_error  = 1'b0;
`endif

   uart_rx_fifo #(
      .P_WIDTH (P_DATA_BITS),
      .P_DEPTH (P_FIFO_DEPTH)
   ) u_fifo (
      .CLK   (CLK),
      .reset (reset),
      .din   (r_shreg),
      .wr_en (r_wr_en),
      .rd_en (rd_en),
      .dout  (data_out),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_multi.sv
`default_nettype none
// ============================================================================
// Module : tb_uart_rx_multi
// Brief  : Self-checking bench for uart_rx_multi against a word-level model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_uart_rx_multi;

   localparam int   c_BIT        = 16;   // one tick per clock, 16 ticks per bit
   localparam int   c_DEPTH      = 16;
   localparam int   c_IDLE_TICKS = 32;
   localparam logic c_PAR_ODD    = 1'b0;

   logic       CLK = 1'b0;
   logic       reset = 1'b1;
   logic       serial_in = 1'b1;
   logic       rd_en = 1'b0;
   logic       clear_errors = 1'b0;
   logic [7:0] data_out;
   logic       fifo_full;
   logic       fifo_empty;
   logic       frame_error;
   logic       overrun_error;
   logic       parity_error;

   int         n_checks = 0;
   int         n_errors = 0;

   logic [7:0] exp_q[$];
   logic       exp_frame = 1'b0;
   logic       exp_overrun = 1'b0;
   logic       exp_parity = 1'b0;
   logic       rx_ready = 1'b0;
   int         hi_run = 0;

   uart_rx_multi #(
      .P_DATA_BITS  (8),
      .P_CLK_HZ     (1600),
      .P_BAUD       (100),
      .P_OVERSAMPLE (16),
      .P_FIFO_DEPTH (c_DEPTH),
      .P_IDLE_BITS  (2),
      .P_PARITY_ODD (0)
   ) dut (
      .CLK           (CLK),
      .reset         (reset),
      .serial_in     (serial_in),
      .rd_en         (rd_en),
      .clear_errors  (clear_errors),
      .data_out      (data_out),
      .fifo_full     (fifo_full),
      .fifo_empty    (fifo_empty),
      .frame_error   (frame_error),
      .overrun_error (overrun_error),
      .parity_error  (parity_error)
   );

   always #5 CLK = ~CLK;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, "_empty"}, 32'(fifo_empty), 32'(exp_q.size() == 0));
      chk({tag, "_full"}, 32'(fifo_full), 32'(exp_q.size() == c_DEPTH));
      if (exp_q.size() > 0) begin
         chk({tag, "_head"}, 32'(data_out), 32'(exp_q[0]));
      end
      chk({tag, "_frame"}, 32'(frame_error), 32'(exp_frame));
      chk({tag, "_overrun"}, 32'(overrun_error), 32'(exp_overrun));
      chk({tag, "_parity"}, 32'(parity_error), 32'(exp_parity));
   endtask

   function automatic logic good_par(input logic [7:0] d);
      return (^d) ^ c_PAR_ODD;
   endfunction

   // A receiver becomes ready once the line has stayed high for the idle qualification.
   task automatic drive(input logic b, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge CLK);
         serial_in = b;
         if (b) begin
            hi_run++;
         end else begin
            if (!rx_ready && hi_run >= c_IDLE_TICKS) rx_ready = 1'b1;
            hi_run = 0;
         end
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par_bit, input logic stop_bit);
      logic took;
      drive(1'b0, c_BIT);
      took = rx_ready;
      for (int k = 0; k < 8; k++) drive(d[k], c_BIT);
`ifdef UART_RX_PARITY_EN
      drive(par_bit, c_BIT);
`endif
      drive(stop_bit, c_BIT);
      if (took) begin
`ifdef UART_RX_PARITY_EN
         if (par_bit != good_par(d)) exp_parity = 1'b1;
`endif
         if (!stop_bit) begin
            exp_frame = 1'b1;
            rx_ready  = 1'b0;
         end else if (par_bit == good_par(d)) begin
            if (exp_q.size() == c_DEPTH) exp_overrun = 1'b1;
            else exp_q.push_back(d);
         end
      end
      drive(1'b1, 4);
   endtask

   task automatic pop();
      @(negedge CLK);
      rd_en = 1'b1;
      hi_run++;
      @(negedge CLK);
      rd_en = 1'b0;
      hi_run++;
      if (exp_q.size() > 0) void'(exp_q.pop_front());
   endtask

   task automatic clear_pulse();
      @(negedge CLK);
      clear_errors = 1'b1;
      hi_run++;
      @(negedge CLK);
      clear_errors = 1'b0;
      hi_run++;
      exp_frame   = 1'b0;
      exp_overrun = 1'b0;
      exp_parity  = 1'b0;
   endtask

   task automatic do_reset(input int n);
      @(negedge CLK);
      reset = 1'b1;
      repeat (n) @(negedge CLK);
      reset = 1'b0;
      exp_q.delete();
      exp_frame   = 1'b0;
      exp_overrun = 1'b0;
      exp_parity  = 1'b0;
      rx_ready    = 1'b0;
      hi_run      = 0;
   endtask

   initial begin
      logic [7:0] d;

      // Reset state
      do_reset(3);
      check_all("reset");
      chk("reset_dout", 32'(data_out), 32'h0);

      // Basic frame after idle qualification
      drive(1'b1, 40);
      send_frame(8'hA5, good_par(8'hA5), 1'b1);
      check_all("t1_rx");
      chk("t1_data", 32'(data_out), 32'hA5);
      pop();
      check_all("t1_pop");

      // Short glitch is not a start bit
      drive(1'b0, 3);
      drive(1'b1, 20);
      check_all("t2_glitch");
      send_frame(8'h3C, good_par(8'h3C), 1'b1);
      check_all("t2_rx");
      chk("t2_data", 32'(data_out), 32'h3C);
      pop();

      // Framing error, then requalification before the next word
      send_frame(8'h55, good_par(8'h55), 1'b0);
      check_all("t3_ferr");
      chk("t3_frame", 32'(frame_error), 32'h1);
      drive(1'b1, 10);
      send_frame(8'h12, good_par(8'h12), 1'b1);
      check_all("t3_early");
      drive(1'b1, 40);
      send_frame(8'h12, good_par(8'h12), 1'b1);
      check_all("t3_rx");
      chk("t3_data", 32'(data_out), 32'h12);
      pop();
      clear_pulse();
      check_all("t3_clear");

      // Fill past capacity without reading
      for (int w = 0; w < 17; w++) begin
         d = 8'(w);
         send_frame(d, good_par(d), 1'b1);
         check_all("t4_fill");
      end
      chk("t4_full", 32'(fifo_full), 32'h1);
      chk("t4_overrun", 32'(overrun_error), 32'h1);
      chk("t4_head", 32'(data_out), 32'h0);
      clear_pulse();
      check_all("t4_clear");
      for (int w = 0; w < 16; w++) begin
         pop();
         check_all("t4_drain");
      end

      // Random words with random gaps and reads
      for (int i = 0; i < 8; i++) begin
         d = 8'($urandom_range(0, 255));
         send_frame(d, good_par(d), 1'b1);
         drive(1'b1, $urandom_range(0, 12));
         check_all("t5_rand");
         if ($urandom_range(0, 1) == 1) begin
            pop();
            check_all("t5_pop");
         end
      end
      while (exp_q.size() > 0) pop();
      check_all("t5_drained");

`ifdef UART_RX_PARITY_EN
      send_frame(8'h07, 1'b1, 1'b1);
      check_all("t6_par_ok");
      chk("t6_data", 32'(data_out), 32'h07);
      pop();
      send_frame(8'h07, 1'b0, 1'b1);
      check_all("t6_par_bad");
      chk("t6_perr", 32'(parity_error), 32'h1);
      clear_pulse();
      check_all("t6_clear");
`endif

      // Reset in the middle of a data word
      send_frame(8'h5A, good_par(8'h5A), 1'b1);
      check_all("t7_pre");
      drive(1'b0, c_BIT);
      for (int k = 0; k < 3; k++) drive(1'b0, c_BIT);
      drive(1'b0, 3);
      do_reset(3);
      check_all("t7_reset");
      chk("t7_dout", 32'(data_out), 32'h0);
      drive(1'b0, 10);
      drive(1'b1, 4 * c_BIT);
      drive(1'b1, c_BIT);
      drive(1'b1, 8);
      check_all("t7_partial");
      send_frame(8'h81, good_par(8'h81), 1'b1);
      check_all("t7_rx");
      chk("t7_data", 32'(data_out), 32'h81);
      pop();
      check_all("t7_pop");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
